// File: rtl/interboard_receiver.sv
// Two-beat, four-phase handshake receiver for the inter-board link.
// Synchronizes the remote request/data and delivers {msg_type, number}.
module interboard_receiver #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] TIMEOUT     = 16'd50000,
    parameter logic [2:0]  RST_MSG     = 3'd7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Request_in,
    input  logic [5:0] inter_data_in,
    output logic       Ack_out,
    output logic       interboard_en,
    output logic [2:0] interboard_msg_type,
    output logic [4:0] interboard_number,
    output logic       interboard_rst,
    output logic       proto_err
);

    typedef enum logic [2:0] {
        IDLE,
        ACK0,
        WAIT1,
        ACK1,
        DELIVER
    } state_t;

    state_t                       state;
    logic [SYNC_STAGES-1:0]       req_sync;
    logic [SYNC_STAGES-1:0][5:0]  data_sync;
    logic                         req_s;
    logic [5:0]                   data_s;
    logic [15:0]                  cnt;
    logic [2:0]                   msg_q;
    logic [4:0]                   num_q;
    logic                         bad;
    logic [2:0]                   fill;
    logic                         armed;

    assign req_s  = req_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];

    // Bring the asynchronous request and data bus into the clk domain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_sync  <= '0;
            data_sync <= '0;
        end else begin
            req_sync  <= {req_sync[SYNC_STAGES-2:0], Request_in};
            data_sync <= {data_sync[SYNC_STAGES-2:0], inter_data_in};
        end
    end

    // After reset, wait for the chain to fill and the request to be low,
    // so a request left high across reset is not taken as a new beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fill  <= '0;
            armed <= 1'b0;
        end else begin
            if (fill != 3'(SYNC_STAGES))
                fill <= fill + 3'd1;
            else if (!req_s)
                armed <= 1'b1;
        end
    end

    // Handshake state machine with registered acknowledge and pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state               <= IDLE;
            Ack_out             <= 1'b0;
            interboard_en       <= 1'b0;
            interboard_rst      <= 1'b0;
            proto_err           <= 1'b0;
            interboard_msg_type <= '0;
            interboard_number   <= '0;
            msg_q               <= '0;
            num_q               <= '0;
            bad                 <= 1'b0;
            cnt                 <= '0;
        end else begin
            interboard_en  <= 1'b0;
            interboard_rst <= 1'b0;
            proto_err      <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (armed && req_s) begin
                        Ack_out <= 1'b1;
                        state   <= ACK0;
                        if (data_s[5]) begin
                            msg_q <= data_s[2:0];
                            bad   <= 1'b0;
                        end else begin
                            bad   <= 1'b1;
                        end
                    end
                end
                ACK0: begin
                    if (!req_s) begin
                        Ack_out <= 1'b0;
                        if (bad) begin
                            proto_err <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            cnt   <= '0;
                            state <= WAIT1;
                        end
                    end
                end
                WAIT1: begin
                    if (req_s) begin
                        Ack_out <= 1'b1;
                        state   <= ACK1;
                        if (!data_s[5])
                            num_q <= data_s[4:0];
                        else
                            bad   <= 1'b1;
                    end else if (cnt == TIMEOUT - 16'd1) begin
                        proto_err <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ACK1: begin
                    if (!req_s) begin
                        Ack_out <= 1'b0;
                        if (bad) begin
                            proto_err <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            state <= DELIVER;
                        end
                    end
                end
                DELIVER: begin
                    interboard_msg_type <= msg_q;
                    interboard_number   <= num_q;
                    interboard_en       <= 1'b1;
                    interboard_rst      <= (msg_q == RST_MSG);
                    state               <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_interboard_receiver.sv
// Directed bench for interboard_receiver.
// Walks through normal, reset, framing, timeout and mid-reset messages.
module tb_interboard_receiver;

    logic       clk = 1'b0;
    logic       rst;
    logic       Request_in;
    logic [5:0] inter_data_in;
    logic       Ack_out;
    logic       interboard_en;
    logic [2:0] interboard_msg_type;
    logic [4:0] interboard_number;
    logic       interboard_rst;
    logic       proto_err;

    int pass_cnt = 0;
    int total_cnt = 0;
    int fail_cnt = 0;
    int en_cnt = 0;
    int rstp_cnt = 0;
    int err_cnt = 0;
    int lone_rst = 0;

    interboard_receiver #(
        .SYNC_STAGES(2),
        .TIMEOUT(16'd20),
        .RST_MSG(3'd7)
    ) dut (
        .clk(clk),
        .rst(rst),
        .Request_in(Request_in),
        .inter_data_in(inter_data_in),
        .Ack_out(Ack_out),
        .interboard_en(interboard_en),
        .interboard_msg_type(interboard_msg_type),
        .interboard_number(interboard_number),
        .interboard_rst(interboard_rst),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    // Pulse counters
    always @(posedge clk) begin
        if (interboard_en) en_cnt++;
        if (interboard_rst) rstp_cnt++;
        if (interboard_rst && !interboard_en) lone_rst++;
        if (proto_err) err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One full four-phase beat; returns 1 ns after the edge where Ack fell.
    task automatic send_beat(input logic [5:0] d);
        int n;
        tick(1);
        inter_data_in = d;
        Request_in = 1'b1;
        n = 0;
        while (Ack_out !== 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        check("ack_rise", 32'(Ack_out), 32'd1);
        Request_in = 1'b0;
        n = 0;
        while (Ack_out !== 1'b0 && n < 20) begin
            tick(1);
            n++;
        end
        check("ack_fall", 32'(Ack_out), 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b0;
        Request_in = 1'b0;
        inter_data_in = '0;
        tick(2);
        check("rst_ack", 32'(Ack_out), 32'd0);
        check("rst_en", 32'(interboard_en), 32'd0);
        check("rst_err", 32'(proto_err), 32'd0);
        check("rst_type", 32'(interboard_msg_type), 32'd0);
        check("rst_num", 32'(interboard_number), 32'd0);
        rst = 1'b1;
        tick(6);

        // Normal message with acknowledge timing on beat 0
        inter_data_in = 6'h22;
        Request_in = 1'b1;
        tick(2);
        check("ack_rise_early", 32'(Ack_out), 32'd0);
        tick(1);
        check("ack_rise_3cyc", 32'(Ack_out), 32'd1);
        Request_in = 1'b0;
        tick(2);
        check("ack_fall_early", 32'(Ack_out), 32'd1);
        tick(1);
        check("ack_fall_3cyc", 32'(Ack_out), 32'd0);
        send_beat(6'h11);
        check("norm_en_pre", 32'(interboard_en), 32'd0);
        tick(1);
        check("norm_en", 32'(interboard_en), 32'd1);
        check("norm_type", 32'(interboard_msg_type), 32'd2);
        check("norm_num", 32'(interboard_number), 32'd17);
        check("norm_rst", 32'(interboard_rst), 32'd0);
        tick(1);
        check("norm_en_drop", 32'(interboard_en), 32'd0);
        check("norm_en_cnt", 32'(en_cnt), 32'd1);
        check("norm_err_cnt", 32'(err_cnt), 32'd0);

        // Reset message
        tick(3);
        send_beat(6'h27);
        send_beat(6'h00);
        tick(1);
        check("rmsg_en", 32'(interboard_en), 32'd1);
        check("rmsg_rst", 32'(interboard_rst), 32'd1);
        check("rmsg_type", 32'(interboard_msg_type), 32'd7);
        check("rmsg_num", 32'(interboard_number), 32'd0);
        tick(1);
        check("rmsg_rst_drop", 32'(interboard_rst), 32'd0);

        // Framing error on beat 0
        tick(3);
        send_beat(6'h05);
        check("frm_err", 32'(proto_err), 32'd1);
        tick(1);
        check("frm_err_drop", 32'(proto_err), 32'd0);
        tick(4);
        check("frm_en_cnt", 32'(en_cnt), 32'd2);
        check("frm_type_hold", 32'(interboard_msg_type), 32'd7);
        check("frm_num_hold", 32'(interboard_number), 32'd0);

        // Timeout after beat 0
        send_beat(6'h23);
        tick(19);
        check("to_early", 32'(proto_err), 32'd0);
        tick(1);
        check("to_err", 32'(proto_err), 32'd1);
        check("to_type_hold", 32'(interboard_msg_type), 32'd7);
        tick(3);
        send_beat(6'h21);
        send_beat(6'h05);
        tick(1);
        check("post_to_en", 32'(interboard_en), 32'd1);
        check("post_to_type", 32'(interboard_msg_type), 32'd1);
        check("post_to_num", 32'(interboard_number), 32'd5);

        // Reset while in ACK1
        tick(3);
        send_beat(6'h24);
        tick(1);
        inter_data_in = 6'h0A;
        Request_in = 1'b1;
        n = 0;
        while (Ack_out !== 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        check("mid_ack1", 32'(Ack_out), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_ack_async", 32'(Ack_out), 32'd0);
        tick(3);
        rst = 1'b1;
        tick(10);
        check("mid_no_ack_stale", 32'(Ack_out), 32'd0);
        check("mid_no_deliver", 32'(en_cnt), 32'd3);
        Request_in = 1'b0;
        tick(5);
        send_beat(6'h26);
        send_beat(6'h1F);
        tick(1);
        check("mid_next_en", 32'(interboard_en), 32'd1);
        check("mid_next_type", 32'(interboard_msg_type), 32'd6);
        check("mid_next_num", 32'(interboard_number), 32'd31);
        check("mid_next_rst", 32'(interboard_rst), 32'd0);
        tick(3);

        check("tot_en", 32'(en_cnt), 32'd4);
        check("tot_rst", 32'(rstp_cnt), 32'd1);
        check("tot_err", 32'(err_cnt), 32'd2);
        check("rst_with_en", 32'(lone_rst), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
